// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared state, opcode and ALU-control encodings for the
//               multicycle controller and the ALU-control block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_WB_ALU   = 4'd7,
        ST_WB_MEM   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_JAL      = 4'd11
    } state_t;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_slti  = 6'b001010;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_jal   = 6'b000011;

    localparam logic [2:0] c_alu_add   = 3'b010;
    localparam logic [2:0] c_alu_rtype = 3'b011;
    localparam logic [2:0] c_alu_sub   = 3'b110;
    localparam logic [2:0] c_alu_slt   = 3'b111;

    localparam logic [1:0] c_pc_src_alu  = 2'b00;
    localparam logic [1:0] c_pc_src_aout = 2'b01;
    localparam logic [1:0] c_pc_src_jump = 2'b10;

    localparam logic [1:0] c_src_b_rt    = 2'b00;
    localparam logic [1:0] c_src_b_four  = 2'b01;
    localparam logic [1:0] c_src_b_imm   = 2'b10;
    localparam logic [1:0] c_src_b_shimm = 2'b11;

    localparam logic [1:0] c_dst_rt = 2'b00;
    localparam logic [1:0] c_dst_rd = 2'b01;
    localparam logic [1:0] c_dst_ra = 2'b10;

    localparam logic [1:0] c_wd_alu = 2'b00;
    localparam logic [1:0] c_wd_mdr = 2'b01;
    localparam logic [1:0] c_wd_pc  = 2'b10;

    // Unknown opcodes map to ST_FETCH, which the controller treats as illegal.
    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            c_op_rtype:          return ST_EXEC_R;
            c_op_addi, c_op_slti: return ST_EXEC_I;
            c_op_lw, c_op_sw:    return ST_MEM_ADDR;
            c_op_beq:            return ST_BRANCH;
            c_op_j:              return ST_JUMP;
            c_op_jal:            return ST_JAL;
            default:             return ST_FETCH;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_cnt.sv
// ============================================================================
// Module      : mem_wait_cnt
// Description : Memory wait counter; counts while inc_i is high, otherwise
//               clears, and flags when MEM_TIMEOUT cycles have elapsed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_cnt #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (inc_i) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= '0;
        end
    end

    assign expired_o = (r_count == CNT_W'(MEM_TIMEOUT));

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multicycle MIPS-style main controller FSM with bounded
//               memory waits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    instr_op_i,
    input  logic               mem_ack_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic               i_or_d_o,
    output logic               ir_write_o,
    output logic               pc_write_o,
    output logic               pc_write_cond_o,
    output logic [1:0]         pc_src_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               reg_write_o,
    output logic [1:0]         reg_dst_o,
    output logic [1:0]         mem_to_reg_o,
    output logic               illegal_o,
    output logic               timeout_o,
    output logic [3:0]         state_o
);

    state_t     r_state;
    state_t     w_state_next;
    state_t     w_decoded;
    logic [5:0] w_op;
    logic       r_is_rtype;
    logic       r_is_slti;
    logic       r_is_sw;
    logic       w_wait_state;
    logic       w_expired;
    logic       w_timeout;
    logic       w_cnt_inc;
    logic [2:0] w_alu_op;

    assign w_op      = 6'(instr_op_i);
    assign w_decoded = decode_next(w_op);

    assign w_wait_state = (r_state == ST_FETCH) || (r_state == ST_MEM_RD) ||
                          (r_state == ST_MEM_WR);
    // A late ack on the expiry cycle still wins over the timeout.
    assign w_timeout = w_wait_state && w_expired && !mem_ack_i;
    assign w_cnt_inc = w_wait_state && !mem_ack_i && !w_expired;

    mem_wait_cnt #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inc_i     (w_cnt_inc),
        .expired_o (w_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_FETCH;
            r_is_rtype <= 1'b0;
            r_is_slti  <= 1'b0;
            r_is_sw    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_DECODE) begin
                r_is_rtype <= (w_op == c_op_rtype);
                r_is_slti  <= (w_op == c_op_slti);
                r_is_sw    <= (w_op == c_op_sw);
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        i_or_d_o        = 1'b0;
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pc_src_o        = c_pc_src_alu;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = c_src_b_rt;
        w_alu_op        = 3'b000;
        reg_write_o     = 1'b0;
        reg_dst_o       = c_dst_rt;
        mem_to_reg_o    = c_wd_alu;
        illegal_o       = 1'b0;
        timeout_o       = 1'b0;

        case (r_state)
            ST_FETCH: begin
                if (w_timeout) begin
                    timeout_o    = 1'b1;
                    w_state_next = ST_FETCH;
                end else begin
                    mem_req_o   = 1'b1;
                    alu_src_b_o = c_src_b_four;
                    w_alu_op    = c_alu_add;
                    if (mem_ack_i) begin
                        ir_write_o   = 1'b1;
                        pc_write_o   = 1'b1;
                        w_state_next = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                alu_src_b_o  = c_src_b_shimm;
                w_alu_op     = c_alu_add;
                w_state_next = w_decoded;
                illegal_o    = (w_decoded == ST_FETCH);
            end
            ST_EXEC_R: begin
                alu_src_a_o  = 1'b1;
                w_alu_op     = c_alu_rtype;
                w_state_next = ST_WB_ALU;
            end
            ST_EXEC_I: begin
                alu_src_a_o  = 1'b1;
                alu_src_b_o  = c_src_b_imm;
                w_alu_op     = r_is_slti ? c_alu_slt : c_alu_add;
                w_state_next = ST_WB_ALU;
            end
            ST_WB_ALU: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = r_is_rtype ? c_dst_rd : c_dst_rt;
                w_state_next = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                alu_src_a_o  = 1'b1;
                alu_src_b_o  = c_src_b_imm;
                w_alu_op     = c_alu_add;
                w_state_next = r_is_sw ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD, ST_MEM_WR: begin
                if (w_timeout) begin
                    timeout_o    = 1'b1;
                    w_state_next = ST_FETCH;
                end else begin
                    mem_req_o = 1'b1;
                    i_or_d_o  = 1'b1;
                    mem_we_o  = (r_state == ST_MEM_WR);
                    if (mem_ack_i) begin
                        w_state_next = (r_state == ST_MEM_RD) ? ST_WB_MEM : ST_FETCH;
                    end
                end
            end
            ST_WB_MEM: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = c_wd_mdr;
                w_state_next = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a_o     = 1'b1;
                w_alu_op        = c_alu_sub;
                pc_write_cond_o = 1'b1;
                pc_src_o        = c_pc_src_aout;
                w_state_next    = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write_o   = 1'b1;
                pc_src_o     = c_pc_src_jump;
                w_state_next = ST_FETCH;
            end
            ST_JAL: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = c_dst_ra;
                mem_to_reg_o = c_wd_pc;
                pc_write_o   = 1'b1;
                pc_src_o     = c_pc_src_jump;
                w_state_next = ST_FETCH;
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    assign alu_op_o = ALUOP_W'(w_alu_op);
    assign state_o  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Scoreboard bench for multicycle_ctrl driven by directed
//               per-cycle vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       req, we, iord, irw, pcw, pcwc;
        logic [1:0] pcsrc;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] aluop;
        logic       rw;
        logic [1:0] rdst, m2r;
        logic       ill, tmo;
    } vec_t;

    typedef struct {
        vec_t  v;
        string name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       ack;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
    logic       alu_src_a, reg_write, illegal, timeout;
    logic [2:0] alu_op;
    logic [3:0] state;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    vec_t F_W, F_A, F_T, DEC, DEC_I, EXR, EXI_A, EXI_S, WBR, WBI, MA, MR, WM, MW, MW_T,
          BR, JP, JL;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .OP_W        (6),
        .ALUOP_W     (3),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .instr_op_i      (op),
        .mem_ack_i       (ack),
        .mem_req_o       (mem_req),
        .mem_we_o        (mem_we),
        .i_or_d_o        (i_or_d),
        .ir_write_o      (ir_write),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .pc_src_o        (pc_src),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .alu_op_o        (alu_op),
        .reg_write_o     (reg_write),
        .reg_dst_o       (reg_dst),
        .mem_to_reg_o    (mem_to_reg),
        .illegal_o       (illegal),
        .timeout_o       (timeout),
        .state_o         (state)
    );

    function automatic vec_t mk(input logic [3:0] st, input logic req, input logic we,
                                input logic iord, input logic irw, input logic pcw,
                                input logic pcwc, input logic [1:0] pcsrc, input logic srca,
                                input logic [1:0] srcb, input logic [2:0] aluop,
                                input logic rw, input logic [1:0] rdst,
                                input logic [1:0] m2r, input logic ill, input logic tmo);
        vec_t v;
        v.st = st; v.req = req; v.we = we; v.iord = iord; v.irw = irw; v.pcw = pcw;
        v.pcwc = pcwc; v.pcsrc = pcsrc; v.srca = srca; v.srcb = srcb; v.aluop = aluop;
        v.rw = rw; v.rdst = rdst; v.m2r = m2r; v.ill = ill; v.tmo = tmo;
        return v;
    endfunction

    task automatic cyc(input logic [5:0] o, input logic a, input vec_t e, input string nm);
        exp_t x;
        op    = o;
        ack   = a;
        x.v    = e;
        x.name = nm;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected vector per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            vec_t act;
            e   = sb.pop_front();
            act = mk(state, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
                     pc_src, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
                     illegal, timeout);
            n_cmp++;
            if (act !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h required %h", e.name, act, e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          st  rq we id irw pcw pcc pcs  sa sb    aop     rw rd     m2r   il to
        F_W   = mk(0,  1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b010, 0, 2'b00, 2'b00, 0, 0);
        F_A   = mk(0,  1, 0, 0, 1, 1, 0, 2'b00, 0, 2'b01, 3'b010, 0, 2'b00, 2'b00, 0, 0);
        F_T   = mk(0,  0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 2'b00, 2'b00, 0, 1);
        DEC   = mk(1,  0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b010, 0, 2'b00, 2'b00, 0, 0);
        DEC_I = mk(1,  0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b010, 0, 2'b00, 2'b00, 1, 0);
        EXR   = mk(2,  0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b011, 0, 2'b00, 2'b00, 0, 0);
        EXI_A = mk(3,  0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 2'b00, 2'b00, 0, 0);
        EXI_S = mk(3,  0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b111, 0, 2'b00, 2'b00, 0, 0);
        WBR   = mk(7,  0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 2'b01, 2'b00, 0, 0);
        WBI   = mk(7,  0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 2'b00, 2'b00, 0, 0);
        MA    = mk(4,  0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 2'b00, 2'b00, 0, 0);
        MR    = mk(5,  1, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 2'b00, 2'b00, 0, 0);
        WM    = mk(8,  0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 2'b00, 2'b01, 0, 0);
        MW    = mk(6,  1, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 2'b00, 2'b00, 0, 0);
        MW_T  = mk(6,  0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 2'b00, 2'b00, 0, 1);
        BR    = mk(9,  0, 0, 0, 0, 0, 1, 2'b01, 1, 2'b00, 3'b110, 0, 2'b00, 2'b00, 0, 0);
        JP    = mk(10, 0, 0, 0, 0, 1, 0, 2'b10, 0, 2'b00, 3'b000, 0, 2'b00, 2'b00, 0, 0);
        JL    = mk(11, 0, 0, 0, 0, 1, 0, 2'b10, 0, 2'b00, 3'b000, 1, 2'b10, 2'b10, 0, 0);

        rst = 1'b1;
        op  = 6'b0;
        ack = 1'b0;
        @(posedge clk);
        #1;
        cyc(6'b000000, 1'b0, F_W, "reset_fetch");
        rst = 1'b0;

        // R-type, zero-wait fetch
        cyc(6'b000000, 1'b1, F_A,   "r_fetch");
        cyc(6'b000000, 1'b0, DEC,   "r_decode");
        cyc(6'b000000, 1'b0, EXR,   "r_exec");
        cyc(6'b000000, 1'b0, WBR,   "r_wb");

        // lw, data ack on the fourth MEM_RD cycle; stray ack in MEM_ADDR ignored
        cyc(6'b000000, 1'b1, F_A,   "lw_fetch");
        cyc(6'b100011, 1'b0, DEC,   "lw_decode");
        cyc(6'b000000, 1'b1, MA,    "lw_addr");
        for (int i = 0; i < 3; i++) cyc(6'b000000, 1'b0, MR, "lw_rd_wait");
        cyc(6'b000000, 1'b1, MR,    "lw_rd_ack");
        cyc(6'b000000, 1'b0, WM,    "lw_wb");

        // jal
        cyc(6'b000000, 1'b1, F_A,   "jal_fetch");
        cyc(6'b000011, 1'b0, DEC,   "jal_decode");
        cyc(6'b000000, 1'b0, JL,    "jal_exec");

        // illegal opcode
        cyc(6'b000000, 1'b1, F_A,   "ill_fetch");
        cyc(6'b111111, 1'b0, DEC_I, "ill_decode");
        cyc(6'b000000, 1'b1, F_A,   "ill_back_fetch");

        // addi (continues from the fetch above)
        cyc(6'b001000, 1'b0, DEC,   "addi_decode");
        cyc(6'b000000, 1'b0, EXI_A, "addi_exec");
        cyc(6'b000000, 1'b0, WBI,   "addi_wb");

        // slti: opcode changes after DECODE must not matter
        cyc(6'b000000, 1'b1, F_A,   "slti_fetch");
        cyc(6'b001010, 1'b0, DEC,   "slti_decode");
        cyc(6'b000000, 1'b0, EXI_S, "slti_exec");
        cyc(6'b000000, 1'b0, WBI,   "slti_wb");

        // beq with stray ack in DECODE
        cyc(6'b000000, 1'b1, F_A,   "beq_fetch");
        cyc(6'b000100, 1'b1, DEC,   "beq_decode");
        cyc(6'b000000, 1'b0, BR,    "beq_exec");

        // j
        cyc(6'b000000, 1'b1, F_A,   "j_fetch");
        cyc(6'b000010, 1'b0, DEC,   "j_decode");
        cyc(6'b000000, 1'b0, JP,    "j_exec");

        // sw with no ack: four wait cycles, then timeout
        cyc(6'b000000, 1'b1, F_A,   "sw_fetch");
        cyc(6'b101011, 1'b0, DEC,   "sw_decode");
        cyc(6'b000000, 1'b0, MA,    "sw_addr");
        for (int i = 0; i < 4; i++) cyc(6'b000000, 1'b0, MW, "sw_wr_wait");
        cyc(6'b000000, 1'b0, MW_T,  "sw_timeout");

        // fetch ack arriving on the expiry cycle completes normally
        for (int i = 0; i < 4; i++) cyc(6'b000000, 1'b0, F_W, "late_fetch_wait");
        cyc(6'b000000, 1'b1, F_A,   "late_fetch_ack");
        cyc(6'b000010, 1'b0, DEC,   "late_decode");
        cyc(6'b000000, 1'b0, JP,    "late_jump");

        // fetch timeout
        for (int i = 0; i < 4; i++) cyc(6'b000000, 1'b0, F_W, "ftmo_wait");
        cyc(6'b000000, 1'b0, F_T,   "ftmo_timeout");
        cyc(6'b000000, 1'b1, F_A,   "ftmo_refetch");

        // reset in the middle of MEM_WR
        cyc(6'b101011, 1'b0, DEC,   "swr_decode");
        cyc(6'b000000, 1'b0, MA,    "swr_addr");
        cyc(6'b000000, 1'b0, MW,    "swr_wait0");
        cyc(6'b000000, 1'b0, MW,    "swr_wait1");
        rst = 1'b1;
        cyc(6'b000000, 1'b0, MW,    "swr_rst_cycle");
        rst = 1'b0;
        cyc(6'b000000, 1'b0, F_W,   "swr_post_rst");
        cyc(6'b000000, 1'b1, F_A,   "swr_refetch");

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
